// File: rtl/pcieifc_ram_pkg.sv
// Shared types and configuration helpers for the PCIe interface SDP RAM.
package pcieifc_ram_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } ram_state_e;

    localparam int unsigned RD_LAT_1 = 1;
    localparam int unsigned RD_LAT_2 = 2;

    // Legal shapes: one or two cycle read latency, at least two words, and
    // no more words than the address can reach.
    function automatic bit ram_cfg_ok(input int unsigned rd_latency,
                                      input int unsigned depth,
                                      input int unsigned addrwidth);
        return ((rd_latency == RD_LAT_1) || (rd_latency == RD_LAT_2)) &&
               (depth >= 2) &&
               (64'(depth) <= (64'd1 << addrwidth));
    endfunction

endpackage

// File: rtl/pcieifc_sdp_mem_core.sv
// Plain inferable simple-dual-port array: one write port, registered read.
// The array and read register carry no reset; vendor macros replace this file only.
module pcieifc_sdp_mem_core #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ADDRWIDTH = 4,
    parameter int unsigned DEPTH     = 1 << ADDRWIDTH
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic                 re,
    input  logic [ADDRWIDTH-1:0] raddr,
    output logic [DATAWIDTH-1:0] rdata
);

    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic [DATAWIDTH-1:0] rdata_q;

    // Write port; read is read-first so a same-edge write yields old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pcieifc_sdp_ram_clr.sv
// SDP RAM with hardware clear sequencer, 1/2-cycle read latency and
// configurable same-address collision behaviour.
module pcieifc_sdp_ram_clr
    import pcieifc_ram_pkg::*;
#(
    parameter int unsigned          DATAWIDTH  = 8,
    parameter int unsigned          ADDRWIDTH  = 4,
    parameter int unsigned          DEPTH      = 1 << ADDRWIDTH,
    parameter int unsigned          RD_LATENCY = 1,
    parameter int unsigned          BYPASS     = 1,
    parameter logic [DATAWIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req,
    output logic                 init_done,
    input  logic                 wea,
    input  logic [ADDRWIDTH-1:0] addra,
    input  logic [DATAWIDTH-1:0] dina,
    input  logic                 reb,
    input  logic [ADDRWIDTH-1:0] addrb,
    output logic [DATAWIDTH-1:0] doutb,
    output logic                 doutb_vld
);

    if (!ram_cfg_ok(RD_LATENCY, DEPTH, ADDRWIDTH)) begin : g_bad_cfg
        $error("pcieifc_sdp_ram_clr: illegal RD_LATENCY or DEPTH");
    end

    localparam logic [ADDRWIDTH:0]   DEPTH_W   = (ADDRWIDTH + 1)'(DEPTH);
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(DEPTH - 1);

    ram_state_e           state_q, state_d;
    logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
    logic                 vld1_q, vld1_d;
    logic                 vld2_q, vld2_d;
    logic                 ovr_sel_q, ovr_sel_d;
    logic [DATAWIDTH-1:0] ovr_data_q, ovr_data_d;
    logic [DATAWIDTH-1:0] dout2_q, dout2_d;

    logic                 wr_in_range, rd_in_range;
    logic                 wr_user, rd_acc, byp_hit;
    logic                 mem_we, mem_re;
    logic [ADDRWIDTH-1:0] mem_waddr;
    logic [DATAWIDTH-1:0] mem_wdata, mem_rdata, stage1;

    // Request decode: user access only in RUN; out-of-range writes dropped.
    always_comb begin
        wr_in_range = ({1'b0, addra} < DEPTH_W);
        rd_in_range = ({1'b0, addrb} < DEPTH_W);
        wr_user     = wea && (state_q == ST_RUN) && wr_in_range;
        rd_acc      = reb && (state_q == ST_RUN);
        byp_hit     = (BYPASS != 0) && wr_user && (addra == addrb);
        mem_re      = rd_acc && rd_in_range;
        mem_we      = (state_q == ST_INIT) || wr_user;
        mem_waddr   = (state_q == ST_INIT) ? cnt_q : addra;
        mem_wdata   = (state_q == ST_INIT) ? INIT_VAL : dina;
    end

    // Clear sequencer: walk 0..DEPTH-1 in INIT, restart on clr_req in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (clr_req) begin
            state_d = ST_INIT;
            cnt_d   = '0;
        end
    end

    // Read path: bypass/out-of-range override captured at the request edge,
    // held alongside the array read register until the next accepted read.
    always_comb begin
        vld1_d     = rd_acc;
        vld2_d     = vld1_q;
        ovr_sel_d  = ovr_sel_q;
        ovr_data_d = ovr_data_q;
        if (rd_acc) begin
            ovr_sel_d  = !rd_in_range || byp_hit;
            ovr_data_d = rd_in_range ? dina : INIT_VAL;
        end
        stage1  = ovr_sel_q ? ovr_data_q : mem_rdata;
        dout2_d = vld1_q ? stage1 : dout2_q;
    end

    // State, counter and read pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            vld1_q     <= 1'b0;
            vld2_q     <= 1'b0;
            // Override selected with zero data so doutb resets to 0 without
            // needing a reset on the array read register.
            ovr_sel_q  <= 1'b1;
            ovr_data_q <= '0;
            dout2_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vld1_q     <= vld1_d;
            vld2_q     <= vld2_d;
            ovr_sel_q  <= ovr_sel_d;
            ovr_data_q <= ovr_data_d;
            dout2_q    <= dout2_d;
        end
    end

    pcieifc_sdp_mem_core #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (addrb),
        .rdata (mem_rdata)
    );

    assign init_done = (state_q == ST_RUN);
    assign doutb     = (RD_LATENCY == RD_LAT_2) ? dout2_q : stage1;
    assign doutb_vld = (RD_LATENCY == RD_LAT_2) ? vld2_q : vld1_q;

endmodule

// File: tb/tb_pcieifc_sdp_ram_clr.sv
// Directed bench: A = latency 1 / bypass, B = latency 2 / old-data,
// C = 12-word array on a 4-bit address, latency 1. All share stimulus.
module tb_pcieifc_sdp_ram_clr;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr_req = 1'b0;
    logic       wea = 1'b0;
    logic [3:0] addra = '0;
    logic [7:0] dina = '0;
    logic       reb = 1'b0;
    logic [3:0] addrb = '0;

    logic       done_a, done_b, done_c;
    logic [7:0] dout_a, dout_b, dout_c;
    logic       vld_a, vld_b, vld_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcieifc_sdp_ram_clr #(.DATAWIDTH(8), .ADDRWIDTH(4), .DEPTH(16), .RD_LATENCY(1),
                          .BYPASS(1), .INIT_VAL(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .init_done(done_a),
        .wea(wea), .addra(addra), .dina(dina), .reb(reb), .addrb(addrb),
        .doutb(dout_a), .doutb_vld(vld_a));

    pcieifc_sdp_ram_clr #(.DATAWIDTH(8), .ADDRWIDTH(4), .DEPTH(16), .RD_LATENCY(2),
                          .BYPASS(0), .INIT_VAL(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .init_done(done_b),
        .wea(wea), .addra(addra), .dina(dina), .reb(reb), .addrb(addrb),
        .doutb(dout_b), .doutb_vld(vld_b));

    pcieifc_sdp_ram_clr #(.DATAWIDTH(8), .ADDRWIDTH(4), .DEPTH(12), .RD_LATENCY(1),
                          .BYPASS(1), .INIT_VAL(8'hA5)) dut_c (
        .clk(clk), .rst(rst), .clr_req(clr_req), .init_done(done_c),
        .wea(wea), .addra(addra), .dina(dina), .reb(reb), .addrb(addrb),
        .doutb(dout_c), .doutb_vld(vld_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wea = 1'b0; reb = 1'b0; clr_req = 1'b0;
    endtask

    // 16 edges after release: init_done must rise exactly on the 16th (12th for C).
    task automatic test_init_timing(input string tag);
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (done_a !== (k >= 16)) begin
                errors++;
                $display("FAIL %s init_done_a step %0d: got %b want %b", tag, k, done_a, (k >= 16));
            end
            checks++;
            if (done_b !== (k >= 16)) begin
                errors++;
                $display("FAIL %s init_done_b step %0d: got %b want %b", tag, k, done_b, (k >= 16));
            end
            checks++;
            if (done_c !== (k >= 12)) begin
                errors++;
                $display("FAIL %s init_done_c step %0d: got %b want %b", tag, k, done_c, (k >= 12));
            end
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        step(); step();
        checks++;
        if ({done_a, vld_a, dout_a} !== 10'd0) begin
            errors++;
            $display("FAIL reset_a: got done=%b vld=%b dout=%h want 0/0/00", done_a, vld_a, dout_a);
        end
        checks++;
        if ({done_b, vld_b, dout_b} !== 10'd0) begin
            errors++;
            $display("FAIL reset_b: got done=%b vld=%b dout=%h want 0/0/00", done_b, vld_b, dout_b);
        end
        rst = 1'b0;
        test_init_timing("reset");
    endtask

    // Back-to-back reads of all 16 words; A answers after 1 cycle, B after 2.
    task automatic test_read_all(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 18; i++) begin
            reb = (i < 16);
            addrb = 4'(i);
            step();
            checks++;
            if (vld_a !== (i < 16) || (i < 16 && dout_a !== exp)) begin
                errors++;
                $display("FAIL %s_a req %0d: got vld=%b dout=%h want vld=%b dout=%h",
                         tag, i, vld_a, dout_a, (i < 16), exp);
            end
            checks++;
            if (vld_b !== (i >= 1 && i < 17) || (i >= 1 && i < 17 && dout_b !== exp)) begin
                errors++;
                $display("FAIL %s_b req %0d: got vld=%b dout=%h want vld=%b dout=%h",
                         tag, i - 1, vld_b, dout_b, (i >= 1 && i < 17), exp);
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        wea = 1'b1; addra = 4'd5; dina = 8'h3C;
        step();
        wea = 1'b0; reb = 1'b1; addrb = 4'd5;
        step();
        checks++;
        if (vld_a !== 1'b1 || dout_a !== 8'h3C) begin
            errors++;
            $display("FAIL wr_rd_a: got vld=%b dout=%h want 1/3c", vld_a, dout_a);
        end
        checks++;
        if (vld_b !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_b_early: got vld=%b want 0", vld_b);
        end
        reb = 1'b0;
        step();
        checks++;
        if (vld_a !== 1'b0 || dout_a !== 8'h3C) begin
            errors++;
            $display("FAIL hold_a: got vld=%b dout=%h want 0/3c", vld_a, dout_a);
        end
        checks++;
        if (vld_b !== 1'b1 || dout_b !== 8'h3C) begin
            errors++;
            $display("FAIL wr_rd_b: got vld=%b dout=%h want 1/3c", vld_b, dout_b);
        end
        step();
    endtask

    task automatic test_collision();
        wea = 1'b1; addra = 4'd9; dina = 8'h11;
        step();
        dina = 8'h77; reb = 1'b1; addrb = 4'd9;
        step();
        checks++;
        if (vld_a !== 1'b1 || dout_a !== 8'h77) begin
            errors++;
            $display("FAIL coll_bypass_a: got vld=%b dout=%h want 1/77", vld_a, dout_a);
        end
        // Read again, then overwrite the word while B's read is still in flight.
        wea = 1'b0;
        step();
        checks++;
        if (vld_b !== 1'b1 || dout_b !== 8'h11) begin
            errors++;
            $display("FAIL coll_old_b: got vld=%b dout=%h want 1/11", vld_b, dout_b);
        end
        reb = 1'b0; wea = 1'b1; dina = 8'h22;
        step();
        checks++;
        if (vld_b !== 1'b1 || dout_b !== 8'h77) begin
            errors++;
            $display("FAIL coll_inflight_b: got vld=%b dout=%h want 1/77", vld_b, dout_b);
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            wea = 1'b1; addra = 4'(i); dina = 8'(8'h10 + i);
            step();
        end
        wea = 1'b0;
        for (int i = 0; i < 6; i++) begin
            reb = (i < 4);
            addrb = 4'(i);
            step();
            checks++;
            if (vld_b !== (i >= 1 && i <= 4) || (i >= 1 && i <= 4 && dout_b !== 8'(8'h10 + i - 1))) begin
                errors++;
                $display("FAIL b2b_b step %0d: got vld=%b dout=%h want vld=%b dout=%h",
                         i, vld_b, dout_b, (i >= 1 && i <= 4), 8'(8'h10 + i - 1));
            end
        end
        idle();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 16; i++) begin
            wea = 1'b1; addra = 4'(i); dina = 8'hFF;
            clr_req = (i == 15);
            step();
        end
        idle();
        for (int k = 0; k < 16; k++) begin
            reb = 1'b1; addrb = 4'(k);
            clr_req = (k == 5);
            step();
            checks++;
            if (done_a !== (k == 15) || done_b !== (k == 15)) begin
                errors++;
                $display("FAIL clr_done step %0d: got a=%b b=%b want %b", k, done_a, done_b, (k == 15));
            end
            checks++;
            if (vld_a !== 1'b0 || vld_b !== 1'b0) begin
                errors++;
                $display("FAIL clr_vld step %0d: got a=%b b=%b want 0", k, vld_a, vld_b);
            end
        end
        idle();
        step();
        test_read_all("clr_read", 8'hA5);
    endtask

    task automatic test_out_of_range();
        wea = 1'b1; addra = 4'd13; dina = 8'h5A;
        step();
        addra = 4'd11; dina = 8'h66;
        step();
        wea = 1'b0; reb = 1'b1; addrb = 4'd13;
        step();
        checks++;
        if (vld_c !== 1'b1 || dout_c !== 8'hA5) begin
            errors++;
            $display("FAIL oor_c: got vld=%b dout=%h want 1/a5", vld_c, dout_c);
        end
        checks++;
        if (dout_a !== 8'h5A) begin
            errors++;
            $display("FAIL oor_a_inrange: got %h want 5a", dout_a);
        end
        addrb = 4'd11;
        step();
        checks++;
        if (vld_c !== 1'b1 || dout_c !== 8'h66) begin
            errors++;
            $display("FAIL last_c: got vld=%b dout=%h want 1/66", vld_c, dout_c);
        end
        idle();
        step();
    endtask

    task automatic test_reset_mid_clear();
        reb = 1'b1; addrb = 4'd0;
        clr_req = 1'b1;
        step();
        idle();
        for (int k = 0; k < 7; k++) step();
        rst = 1'b1;
        #1;
        checks++;
        if ({done_a, vld_a, dout_a} !== 10'd0) begin
            errors++;
            $display("FAIL midrst_a: got done=%b vld=%b dout=%h want 0/0/00", done_a, vld_a, dout_a);
        end
        checks++;
        if ({done_b, vld_b, dout_b} !== 10'd0) begin
            errors++;
            $display("FAIL midrst_b: got done=%b vld=%b dout=%h want 0/0/00", done_b, vld_b, dout_b);
        end
        step();
        rst = 1'b0;
        test_init_timing("midrst");
        test_read_all("midrst_read", 8'hA5);
    endtask

    initial begin
        test_reset();
        test_read_all("init_read", 8'hA5);
        test_write_read();
        test_collision();
        test_back_to_back();
        test_clear();
        test_out_of_range();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
